// File: rtl/uz_nn_acc_hls_deadlock_report_unit.sv
// uz_nn_acc_hls_deadlock_report_unit
//
// Central controller of the HLS dataflow deadlock-detection network. It waits
// until some detect unit has reported a deadlock for CONFIRM_CYCLES consecutive
// cycles. It then elects the lowest-indexed reporting process as origin and
// raises the global deadlock flag. While the report token travels around the
// dependency cycle, it records the processes the token visits. It clears the
// token once the token is back at the origin.
//
// Ports
//   clock            system clock, rising edge
//   reset            asynchronous, active-high reset
//   dl_in_vec        per-process deadlock flags from the detect units
//   token_vld_vec    per-process "holds the report token" flags
//   origin           one-hot origin select, high for the single ORIGIN cycle
//   token_clear      combinational: token is back at the origin during TRACE
//   dl_detect_out    global deadlock flag (ORIGIN, TRACE, DONE)
//   origin_id        index of the elected origin
//   cycle_proc_vec   processes visited by the token so far
//   report_vld       one-cycle pulse: new processes joined cycle_proc_vec
//   report_proc_vec  processes newly visited, valid with report_vld
//   report_done      sticky: trace finished
//   report_err       sticky: trace aborted because no process held the token
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no deadlock flag seen
// CONFIRM | deadlock flags continuously nonzero, waiting for confirmation
// ORIGIN  | single cycle: origin select pulsed to the elected process
// TRACE   | following the token around the dependency cycle
// DONE    | terminal until reset; results held for readout

module uz_nn_acc_hls_deadlock_report_unit #(
    parameter int PROC_NUM       = 4,
    parameter int CONFIRM_CYCLES = 4,
    parameter int TOKEN_TIMEOUT  = 64,
    localparam int ID_W          = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    input  logic [PROC_NUM-1:0] token_vld_vec,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic                dl_detect_out,
    output logic [ID_W-1:0]     origin_id,
    output logic [PROC_NUM-1:0] cycle_proc_vec,
    output logic                report_vld,
    output logic [PROC_NUM-1:0] report_proc_vec,
    output logic                report_done,
    output logic                report_err
);

    // Both timers are down-counters holding the number of qualifying cycles
    // still needed; the terminal count is 1 (the current cycle is the last).
    localparam int CONF_W = $clog2(CONFIRM_CYCLES + 1);
    localparam int TO_W   = $clog2(TOKEN_TIMEOUT + 1);

    localparam logic [CONF_W-1:0] CONF_LOAD = CONF_W'(CONFIRM_CYCLES - 1);
    localparam logic [CONF_W-1:0] CONF_TC   = CONF_W'(1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TOKEN_TIMEOUT);
    localparam logic [TO_W-1:0]   TO_TC     = TO_W'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONFIRM = 3'd1,
        ORIGIN  = 3'd2,
        TRACE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state;
    logic [CONF_W-1:0]   conf_cnt;
    logic [TO_W-1:0]     to_cnt;

    logic [ID_W-1:0]     elect_id;
    logic [PROC_NUM-1:0] elect_onehot;
    logic [PROC_NUM-1:0] new_vec;
    logic                tok_at_origin;

    // Lowest set index wins so that simultaneous reporters elect deterministically.
    function automatic logic [ID_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        elect_id      = lowest_idx(dl_in_vec);
        elect_onehot  = PROC_NUM'(1) << elect_id;
        new_vec       = token_vld_vec & ~cycle_proc_vec;
        tok_at_origin = token_vld_vec[origin_id];
    end

    // Combinational so the detect unit sees the clear in the same cycle the
    // token sits at the origin and suppresses re-issue at that edge.
    assign token_clear = (state == TRACE) && tok_at_origin;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            conf_cnt        <= '0;
            to_cnt          <= '0;
            origin          <= '0;
            dl_detect_out   <= 1'b0;
            origin_id       <= '0;
            cycle_proc_vec  <= '0;
            report_vld      <= 1'b0;
            report_proc_vec <= '0;
            report_done     <= 1'b0;
            report_err      <= 1'b0;
        end else begin
            report_vld <= 1'b0;
            case (state)
                IDLE: begin
                    conf_cnt <= '0;
                    if (|dl_in_vec) begin
                        if (CONFIRM_CYCLES == 1) begin
                            state          <= ORIGIN;
                            origin_id      <= elect_id;
                            origin         <= elect_onehot;
                            cycle_proc_vec <= elect_onehot;
                            dl_detect_out  <= 1'b1;
                        end else begin
                            state    <= CONFIRM;
                            conf_cnt <= CONF_LOAD;
                        end
                    end
                end

                CONFIRM: begin
                    if (!(|dl_in_vec)) begin
                        state    <= IDLE;
                        conf_cnt <= '0;
                    end else if (conf_cnt == CONF_TC) begin
                        // Election uses the final confirming sample.
                        state          <= ORIGIN;
                        conf_cnt       <= '0;
                        origin_id      <= elect_id;
                        origin         <= elect_onehot;
                        cycle_proc_vec <= elect_onehot;
                        dl_detect_out  <= 1'b1;
                    end else begin
                        conf_cnt <= conf_cnt - 1'b1;
                    end
                end

                ORIGIN: begin
                    state  <= TRACE;
                    origin <= '0;
                    to_cnt <= TO_LOAD;
                end

                TRACE: begin
                    if (|new_vec) begin
                        report_vld      <= 1'b1;
                        report_proc_vec <= new_vec;
                        cycle_proc_vec  <= cycle_proc_vec | token_vld_vec;
                    end
                    // Return implies a token holder exists, so it always
                    // takes precedence over the idle timeout.
                    if (tok_at_origin) begin
                        state       <= DONE;
                        report_done <= 1'b1;
                    end else if (|token_vld_vec) begin
                        to_cnt <= TO_LOAD;
                    end else if (to_cnt == TO_TC) begin
                        state       <= DONE;
                        report_done <= 1'b1;
                        report_err  <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end

                DONE: begin
                    state <= DONE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uz_nn_acc_hls_deadlock_report_unit.sv
module tb_uz_nn_acc_hls_deadlock_report_unit;

    localparam int PN = 4;
    localparam int CC = 4;
    localparam int TT = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic [PN-1:0] dl_in_vec;
    logic [PN-1:0] token_vld_vec;
    logic [PN-1:0] origin;
    logic          token_clear;
    logic          dl_detect_out;
    logic [1:0]    origin_id;
    logic [PN-1:0] cycle_proc_vec;
    logic          report_vld;
    logic [PN-1:0] report_proc_vec;
    logic          report_done;
    logic          report_err;

    // Second instance with the minimum confirmation length.
    logic [PN-1:0] dl_min;
    logic [PN-1:0] tok_min;
    logic [PN-1:0] origin_min;
    logic          token_clear_min;
    logic          dl_detect_min;
    logic [1:0]    origin_id_min;
    logic [PN-1:0] cpv_min;
    logic          rep_vld_min;
    logic [PN-1:0] rep_vec_min;
    logic          done_min;
    logic          err_min;

    int n_total = 0;
    int n_bad   = 0;
    bit cmp_en  = 1'b0;

    uz_nn_acc_hls_deadlock_report_unit #(
        .PROC_NUM(PN), .CONFIRM_CYCLES(CC), .TOKEN_TIMEOUT(TT)
    ) dut (
        .clock(clock), .reset(reset),
        .dl_in_vec(dl_in_vec), .token_vld_vec(token_vld_vec),
        .origin(origin), .token_clear(token_clear),
        .dl_detect_out(dl_detect_out), .origin_id(origin_id),
        .cycle_proc_vec(cycle_proc_vec), .report_vld(report_vld),
        .report_proc_vec(report_proc_vec), .report_done(report_done),
        .report_err(report_err)
    );

    uz_nn_acc_hls_deadlock_report_unit #(
        .PROC_NUM(PN), .CONFIRM_CYCLES(1), .TOKEN_TIMEOUT(TT)
    ) dut_min (
        .clock(clock), .reset(reset),
        .dl_in_vec(dl_min), .token_vld_vec(tok_min),
        .origin(origin_min), .token_clear(token_clear_min),
        .dl_detect_out(dl_detect_min), .origin_id(origin_id_min),
        .cycle_proc_vec(cpv_min), .report_vld(rep_vld_min),
        .report_proc_vec(rep_vec_min), .report_done(done_min),
        .report_err(err_min)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // ---------------- behavioural model ----------------
    // Tracks how long deadlock flags have persisted, whether an origin has
    // been elected, and the token's progress, in plain counts and sets.
    int            m_run;
    int            m_quiet;
    bit            m_in_origin, m_tracing, m_done, m_err, m_rep_vld;
    int            m_oid;
    logic [PN-1:0] m_visited, m_rep_vec;

    function automatic int first_set(input logic [PN-1:0] v);
        for (int i = 0; i < PN; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic m_clear();
        m_run = 0; m_quiet = 0; m_in_origin = 0; m_tracing = 0;
        m_done = 0; m_err = 0; m_rep_vld = 0; m_oid = 0;
        m_visited = '0; m_rep_vec = '0;
    endtask

    task automatic m_step();
        logic [PN-1:0] nv;
        m_rep_vld = 0;
        if (m_done) begin
        end else if (m_in_origin) begin
            m_in_origin = 0;
            m_tracing   = 1;
            m_quiet     = 0;
        end else if (m_tracing) begin
            nv = token_vld_vec & ~m_visited;
            if (nv != 0) begin
                m_rep_vld = 1;
                m_rep_vec = nv;
                m_visited = m_visited | token_vld_vec;
            end
            if (token_vld_vec[m_oid]) begin
                m_done = 1; m_tracing = 0;
            end else if (token_vld_vec == 0) begin
                m_quiet++;
                if (m_quiet == TT) begin
                    m_done = 1; m_err = 1; m_tracing = 0;
                end
            end else begin
                m_quiet = 0;
            end
        end else if (dl_in_vec != 0) begin
            m_run++;
            if (m_run == CC) begin
                m_oid       = first_set(dl_in_vec);
                m_visited   = PN'(1) << m_oid;
                m_in_origin = 1;
                m_run       = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) m_clear();
            else       m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (cmp_en) begin
                chk("cyc_origin", 32'(origin), m_in_origin ? 32'(PN'(1) << m_oid) : 32'd0);
                chk("cyc_dl_detect", 32'(dl_detect_out), 32'(m_in_origin | m_tracing | m_done));
                chk("cyc_origin_id", 32'(origin_id), 32'(m_oid));
                chk("cyc_cycle_proc_vec", 32'(cycle_proc_vec), 32'(m_visited));
                chk("cyc_report_vld", 32'(report_vld), 32'(m_rep_vld));
                if (m_rep_vld) chk("cyc_report_proc_vec", 32'(report_proc_vec), 32'(m_rep_vec));
                chk("cyc_report_done", 32'(report_done), 32'(m_done));
                chk("cyc_report_err", 32'(report_err), 32'(m_err));
                chk("cyc_token_clear", 32'(token_clear), 32'(m_tracing & token_vld_vec[m_oid]));
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        reset = 1'b1; dl_in_vec = '0; token_vld_vec = '0; dl_min = '0; tok_min = '0;
        tick(); tick();
        chk("rst_origin", 32'(origin), 0);
        chk("rst_dl_detect", 32'(dl_detect_out), 0);
        chk("rst_cpv", 32'(cycle_proc_vec), 0);
        chk("rst_done", 32'(report_done), 0);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Minimum confirm: a single-cycle flag elects on the next cycle.
        dl_min = 4'b1000;
        tick();
        chk("min_origin", 32'(origin_min), 32'h8);
        chk("min_origin_id", 32'(origin_id_min), 3);
        chk("min_dl_detect", 32'(dl_detect_min), 1);
        dl_min = '0;
        tick();
        chk("min_origin_drop", 32'(origin_min), 0);

        // Glitch rejection: three cycles is one short.
        dl_in_vec = 4'b0100;
        repeat (3) tick();
        dl_in_vec = '0;
        repeat (4) tick();
        chk("glitch_dl_detect", 32'(dl_detect_out), 0);
        chk("glitch_origin", 32'(origin), 0);

        // Election with two reporters; lowest index wins.
        dl_in_vec = 4'b0110;
        repeat (3) tick();
        chk("elect_not_yet", 32'(origin), 0);
        tick();
        chk("elect_origin", 32'(origin), 32'h2);
        chk("elect_origin_id", 32'(origin_id), 1);
        chk("elect_dl_detect", 32'(dl_detect_out), 1);
        dl_in_vec = '0;
        tick();
        chk("elect_origin_one_cycle", 32'(origin), 0);
        token_vld_vec = 4'b0100;
        tick();
        chk("trace_rep1_vld", 32'(report_vld), 1);
        chk("trace_rep1_vec", 32'(report_proc_vec), 32'h4);
        token_vld_vec = 4'b1000;
        tick();
        chk("trace_rep2_vld", 32'(report_vld), 1);
        chk("trace_rep2_vec", 32'(report_proc_vec), 32'h8);
        token_vld_vec = 4'b0010;
        #1;
        chk("trace_token_clear", 32'(token_clear), 1);
        tick();
        token_vld_vec = '0;
        chk("trace_done", 32'(report_done), 1);
        chk("trace_cpv", 32'(cycle_proc_vec), 32'hE);
        chk("trace_err", 32'(report_err), 0);
        chk("trace_tc_off_in_done", 32'(token_clear), 0);

        // Timeout.
        do_reset();
        dl_in_vec = 4'b0001;
        repeat (4) tick();
        dl_in_vec = '0;
        tick();
        n = 0;
        while (!report_done && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_len", 32'(n), TT);
        chk("timeout_err", 32'(report_err), 1);
        chk("timeout_done", 32'(report_done), 1);

        // Simultaneous return and new holder.
        do_reset();
        dl_in_vec = 4'b0001;
        repeat (4) tick();
        dl_in_vec = '0;
        tick();
        token_vld_vec = 4'b1001;
        #1;
        chk("sim_token_clear", 32'(token_clear), 1);
        tick();
        token_vld_vec = '0;
        chk("sim_rep_vld", 32'(report_vld), 1);
        chk("sim_rep_vec", 32'(report_proc_vec), 32'h8);
        chk("sim_done", 32'(report_done), 1);
        chk("sim_err", 32'(report_err), 0);

        // Reset mid-trace takes effect without a clock edge.
        do_reset();
        dl_in_vec = 4'b0001;
        repeat (4) tick();
        dl_in_vec = '0;
        tick();
        token_vld_vec = 4'b0010;
        tick();
        #1;
        reset = 1'b1;
        #1;
        chk("arst_dl_detect", 32'(dl_detect_out), 0);
        chk("arst_cpv", 32'(cycle_proc_vec), 0);
        chk("arst_rep_vld", 32'(report_vld), 0);
        chk("arst_rep_vec", 32'(report_proc_vec), 0);
        chk("arst_origin_id", 32'(origin_id), 0);
        chk("arst_token_clear", 32'(token_clear), 0);
        token_vld_vec = '0;
        tick();
        reset = 1'b0;
        dl_in_vec = 4'b1000;
        repeat (4) tick();
        chk("fresh_origin", 32'(origin), 32'h8);
        chk("fresh_origin_id", 32'(origin_id), 3);
        dl_in_vec = '0;
        repeat (3) tick();

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
